dl11_console_bank: RTL and testbench
====================================

# dl11_console_bank

Parametrised bank of NCH DL11-style console serial register sets (RCSR/RBUF/XCSR/XBUF), each channel with a receive FIFO and per-direction interrupt enables. Each channel sits between the DCJ11 memory/IO decode, which supplies single-cycle bus strobes already synchronised to sys_clk, and one uart_rx/uart_tx pair. It extends the single-channel, unbuffered console register logic to multiple channels, buffered receive and interrupt requests.

## Interface

- NCH, 2, number of channels (1..8)
- BASE_ADRS, 16'o177560, byte address of channel 0 RCSR
- CH_STRIDE, 16'o10, address step between channels (channel n base = BASE_ADRS + n*CH_STRIDE)
- FIFO_AW, 4, log2 of receive FIFO depth per channel (depth 16)

- sys_clk  in  1  system clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high reset
- bus_addr  in  16  byte address of current cycle
- bus_wdata  in  16  write data
- bus_rd_stb  in  1  one-cycle read strobe, bus_addr valid
- bus_wr_stb  in  1  one-cycle write strobe, bus_addr/bus_wdata valid
- bus_byte  in  1  1 = byte write, lane selected by bus_addr[0]
- bus_rdata  out  16  read data, combinational from bus_addr
- bus_hit  out  1  bus_addr decodes to any register of the bank
- rx_data  in  8*NCH  channel n byte in [8n+7:8n]
- rx_data_ready  in  NCH  level, uart_rx holds a byte
- rx_clear  out  NCH  acknowledge to uart_rx
- tx_data  out  8*NCH  byte to uart_tx
- tx_send  out  NCH  transmit request
- tx_ready  in  NCH  uart_tx idle
- irq_rx  out  NCH  receive interrupt request, level
- irq_tx  out  NCH  transmit interrupt request, level

## Operation

- Register map per channel, offsets +0 RCSR, +2 RBUF, +4 XCSR, +6 XBUF. Decode ignores bus_addr[0]. Unmapped bits read 0.
- RCSR: bit7 DONE = FIFO non-empty (RO). Bit6 RIE (R/W). Word writes and even-byte writes update RIE. Odd-byte writes are ignored.
- RBUF: [7:0] = FIFO head, or 0 when empty. A bus_rd_stb to RBUF pops one entry if non-empty. A read when empty has no effect. Writes are ignored.
- XCSR: bit7 READY = tx_ready & ~tx_send (RO). Bit6 XIE (R/W). Write rules are the same as RCSR.
- XBUF: reads return the last tx_data. A word write or even-byte write with READY=1 loads tx_data from bus_wdata[7:0] and sets tx_send. Writes with READY=0 are dropped. Odd-byte writes are ignored.
- tx_send handshake: tx_send is set by a write and stays high until sampled tx_ready=0, then clears. It never clears while tx_ready=1.
- Receive push: accept when rx_data_ready=1, rx_clear=0, and the FIFO is not full or is popped in the same cycle. Acceptance writes rx_data into the FIFO and sets rx_clear. rx_clear stays high until rx_data_ready=0, then clears.
- Receive backpressure: while the FIFO is full, the byte stays in uart_rx and rx_clear remains 0.
- FIFO: circular, with FIFO_AW-bit read/write pointers that wrap modulo depth, plus an occupancy count of FIFO_AW+1 bits.
  - Push and pop in the same cycle leave the count unchanged.
  - Push and pop on a full FIFO is legal.
  - Pop on an empty FIFO and push on a full FIFO are both no-ops.
- Interrupts: irq_rx[n] = RIE & DONE. irq_tx[n] = XIE & READY. Both are combinational from registered state.
- Channels are fully independent. Only one bus access occurs per cycle.

## Timing

- Reset (synchronous, takes effect at the next edge) forces all of the following, with no partial state surviving mid-transfer:
  - FIFOs empty, pointers 0
  - RIE = XIE = 0
  - tx_data = 0, tx_send = 0, rx_clear = 0
  - irq_rx = irq_tx = 0
  - bus_rdata follows bus_addr
- Read: bus_rdata is valid in the same cycle as bus_rd_stb. A pop updates the head on the next edge, so RCSR DONE reflects the pop one cycle after the strobe.
- XBUF write at edge k: tx_send=1 and READY=0 from k. Earliest tx_send clear is the edge after tx_ready is seen low.
- rx accept at edge k: DONE=1 from k. rx_clear=1 from k until the edge after rx_data_ready falls.
- CSR write: IE changes at the strobe edge. irq reflects it in the following cycle.

## Test plan

- Reset, then read 177560/177564 (tx_ready=1) -> 000000/000200; irq all 0; rx_clear = tx_send = 0.
- Send bytes 0x41 and 0x42 to channel 0 via the rx_data_ready/rx_clear handshake, then read RBUF twice -> 0x0041, 0x0042. RCSR reads 000200 after the first read and 000000 after the second.
- Push 17 bytes into a 16-deep FIFO -> the 17th is held with rx_clear=0. Read RBUF once -> the 17th is accepted in that cycle or the next. A drain returns all 17 bytes in order, with pointer wrap exercised.
- Write RCSR=000100 with the FIFO empty -> irq_rx[0]=0. Push a byte -> irq_rx[0]=1. Pop it -> irq_rx[0]=0.
- Write XBUF=0x55 -> tx_send=1, XCSR=000000. Drop tx_ready -> tx_send clears. A second write while tx_ready=0 is dropped, and tx_data stays 0x55.
- Channel 1 at 177570 receives 0x33 while channel 0 transmits -> no cross-channel effects. A byte write to odd address 177571 leaves RIE unchanged.

Source files
------------

// File: rtl/dl11_console_bank.sv
// Bank of NCH DL11-style console register sets (RCSR/RBUF/XCSR/XBUF) with a
// receive FIFO per channel and per-direction interrupt requests.
module dl11_console_bank #(
  parameter int          NCH       = 2,
  parameter logic [15:0] BASE_ADRS = 16'o177560,
  parameter logic [15:0] CH_STRIDE = 16'o10,
  parameter int          FIFO_AW   = 4
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic [15:0]        bus_addr,
  input  logic [15:0]        bus_wdata,
  input  logic               bus_rd_stb,
  input  logic               bus_wr_stb,
  input  logic               bus_byte,
  output logic [15:0]        bus_rdata,
  output logic               bus_hit,
  input  logic [8*NCH-1:0]   rx_data,
  input  logic [NCH-1:0]     rx_data_ready,
  output logic [NCH-1:0]     rx_clear,
  output logic [8*NCH-1:0]   tx_data,
  output logic [NCH-1:0]     tx_send,
  input  logic [NCH-1:0]     tx_ready,
  output logic [NCH-1:0]     irq_rx,
  output logic [NCH-1:0]     irq_tx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [1:0] {
    REG_RCSR = 2'd0,
    REG_RBUF = 2'd1,
    REG_XCSR = 2'd2,
    REG_XBUF = 2'd3
  } reg_sel_e;

  logic [NCH-1:0] ch_hit;
  logic [15:0]    ch_rdata [NCH];

  // Writes to the odd byte lane never touch any register bit we implement.
  logic lane_ok;
  assign lane_ok = ~bus_byte | ~bus_addr[0];

  logic unused_wdata_hi;
  assign unused_wdata_hi = &{1'b0, bus_wdata[15:8]};

  genvar n;
  generate
    for (n = 0; n < NCH; n++) begin : g_ch
      localparam logic [15:0] CH_BASE = 16'(BASE_ADRS + CH_STRIDE * n);

      logic [15:0]        off;
      logic               hit;
      reg_sel_e           sel;
      logic [7:0]         mem [DEPTH];
      logic [FIFO_AW-1:0] rd_ptr;
      logic [FIFO_AW-1:0] wr_ptr;
      logic [FIFO_AW:0]   count;
      logic               rie;
      logic               xie;
      logic [7:0]         txd_q;
      logic               send_q;
      logic               clear_q;
      logic               empty;
      logic               full;
      logic               ready;
      logic               pop;
      logic               push;
      logic               wr_acc;
      logic               xbuf_load;
      logic [7:0]         head;
      logic [15:0]        rd_word;
      logic               unused_off;

      assign off        = bus_addr - CH_BASE;
      assign hit        = (off[15:3] == 13'd0);
      assign sel        = reg_sel_e'(off[2:1]);
      assign unused_off = off[0];

      assign empty = (count == '0);
      assign full  = (count == CNT_FULL);
      assign ready = tx_ready[n] & ~send_q;
      assign head  = empty ? 8'h00 : mem[rd_ptr];

      // A full FIFO still accepts when the same cycle pops the head.
      assign pop       = bus_rd_stb & hit & (sel == REG_RBUF) & ~empty;
      assign push      = rx_data_ready[n] & ~clear_q & (~full | pop);
      assign wr_acc    = bus_wr_stb & hit & lane_ok;
      assign xbuf_load = wr_acc & (sel == REG_XBUF) & ready;

      always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= rx_data[8*n +: 8];
      end

      always_ff @(posedge sys_clk) begin
        if (reset) begin
          rd_ptr  <= '0;
          wr_ptr  <= '0;
          count   <= '0;
          rie     <= 1'b0;
          xie     <= 1'b0;
          txd_q   <= 8'h00;
          send_q  <= 1'b0;
          clear_q <= 1'b0;
        end else begin
          if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
          if (push) wr_ptr <= wr_ptr + PTR_ONE;
          case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
          endcase

          if (wr_acc && sel == REG_RCSR) rie <= bus_wdata[6];
          if (wr_acc && sel == REG_XCSR) xie <= bus_wdata[6];

          // tx_send holds until the transmitter is seen busy.
          if (xbuf_load) begin
            txd_q  <= bus_wdata[7:0];
            send_q <= 1'b1;
          end else if (send_q && !tx_ready[n]) begin
            send_q <= 1'b0;
          end

          if (push)                   clear_q <= 1'b1;
          else if (!rx_data_ready[n]) clear_q <= 1'b0;
        end
      end

      always_comb begin
        rd_word = 16'h0000;
        case (sel)
          REG_RCSR: rd_word = {8'h00, ~empty, rie, 6'b000000};
          REG_RBUF: rd_word = {8'h00, head};
          REG_XCSR: rd_word = {8'h00, ready, xie, 6'b000000};
          REG_XBUF: rd_word = {8'h00, txd_q};
          default:  rd_word = 16'h0000;
        endcase
        if (!hit) rd_word = 16'h0000;
      end

      assign ch_hit[n]         = hit;
      assign ch_rdata[n]       = rd_word;
      assign rx_clear[n]       = clear_q;
      assign tx_send[n]        = send_q;
      assign tx_data[8*n +: 8] = txd_q;
      assign irq_rx[n]         = rie & ~empty;
      assign irq_tx[n]         = xie & ready;
    end
  endgenerate

  // Channel windows do not overlap, so OR-ing the per-channel words is a mux.
  always_comb begin
    bus_rdata = 16'h0000;
    for (int i = 0; i < NCH; i++) bus_rdata = bus_rdata | ch_rdata[i];
  end

  assign bus_hit = |ch_hit;

endmodule

// File: tb/tb_dl11_console_bank.sv
// Bench for dl11_console_bank: directed scenarios with literal expectations,
// then random traffic checked every cycle against a queue-based model.
module tb_dl11_console_bank;

  localparam int          NCH   = 2;
  localparam logic [15:0] BASE  = 16'o177560;
  localparam int          DEPTH = 16;

  logic               sys_clk;
  logic               reset;
  logic [15:0]        bus_addr;
  logic [15:0]        bus_wdata;
  logic               bus_rd_stb;
  logic               bus_wr_stb;
  logic               bus_byte;
  logic [15:0]        bus_rdata;
  logic               bus_hit;
  logic [8*NCH-1:0]   rx_data;
  logic [NCH-1:0]     rx_data_ready;
  logic [NCH-1:0]     rx_clear;
  logic [8*NCH-1:0]   tx_data;
  logic [NCH-1:0]     tx_send;
  logic [NCH-1:0]     tx_ready;
  logic [NCH-1:0]     irq_rx;
  logic [NCH-1:0]     irq_tx;

  dl11_console_bank #(
    .NCH(NCH), .BASE_ADRS(BASE), .CH_STRIDE(16'o10), .FIFO_AW(4)
  ) dut (
    .sys_clk(sys_clk), .reset(reset),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rd_stb(bus_rd_stb), .bus_wr_stb(bus_wr_stb), .bus_byte(bus_byte),
    .bus_rdata(bus_rdata), .bus_hit(bus_hit),
    .rx_data(rx_data), .rx_data_ready(rx_data_ready), .rx_clear(rx_clear),
    .tx_data(tx_data), .tx_send(tx_send), .tx_ready(tx_ready),
    .irq_rx(irq_rx), .irq_tx(irq_tx)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Model: one queue of tagged bytes holds every channel's receive backlog.
  typedef struct {
    int         ch;
    logic [7:0] data;
  } rx_ent_t;

  rx_ent_t    mq[$];
  bit         m_rie [NCH];
  bit         m_xie [NCH];
  bit         m_txs [NCH];
  bit         m_rxc [NCH];
  logic [7:0] m_txd [NCH];

  function automatic int q_count(input int ch);
    int c = 0;
    foreach (mq[i]) if (mq[i].ch == ch) c++;
    return c;
  endfunction

  function automatic logic [7:0] q_head(input int ch);
    foreach (mq[i]) if (mq[i].ch == ch) return mq[i].data;
    return 8'h00;
  endfunction

  function automatic void q_pop(input int ch);
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].ch == ch) begin
        mq.delete(i);
        return;
      end
  endfunction

  function automatic void decode(input logic [15:0] a, output bit hit,
                                 output int ch, output int rg);
    int off;
    off = int'(a) - int'(BASE);
    hit = (off >= 0) && (off < NCH * 8);
    ch  = hit ? off / 8 : 0;
    rg  = hit ? (off % 8) / 2 : 0;
  endfunction

  function automatic logic [15:0] model_rdata(input logic [15:0] a);
    bit h;
    int c, r;
    decode(a, h, c, r);
    if (!h) return 16'h0000;
    case (r)
      0: return (q_count(c) > 0 ? 16'o200 : 16'o0) | (m_rie[c] ? 16'o100 : 16'o0);
      1: return {8'h00, q_head(c)};
      2: return ((tx_ready[c] && !m_txs[c]) ? 16'o200 : 16'o0) | (m_xie[c] ? 16'o100 : 16'o0);
      default: return {8'h00, m_txd[c]};
    endcase
  endfunction

  always @(posedge sys_clk) begin : model_update
    bit h, even_ok, pop, push, rdy, wr;
    int c, r, cnt;
    if (reset) begin
      mq.delete();
      for (int i = 0; i < NCH; i++) begin
        m_rie[i] = 0; m_xie[i] = 0; m_txs[i] = 0; m_rxc[i] = 0; m_txd[i] = 8'h00;
      end
    end else begin
      decode(bus_addr, h, c, r);
      even_ok = !bus_byte || !bus_addr[0];
      for (int i = 0; i < NCH; i++) begin
        cnt  = q_count(i);
        pop  = bus_rd_stb && h && c == i && r == 1 && cnt > 0;
        push = rx_data_ready[i] && !m_rxc[i] && (cnt < DEPTH || pop);
        rdy  = tx_ready[i] && !m_txs[i];
        if (pop) q_pop(i);
        if (push) mq.push_back('{ch: i, data: rx_data[8*i +: 8]});
        m_rxc[i] = push ? 1'b1 : (m_rxc[i] && rx_data_ready[i]);
        wr = bus_wr_stb && h && c == i && even_ok;
        if (wr && r == 0) m_rie[i] = bus_wdata[6];
        if (wr && r == 2) m_xie[i] = bus_wdata[6];
        if (wr && r == 3 && rdy) begin
          m_txd[i] = bus_wdata[7:0];
          m_txs[i] = 1'b1;
        end else if (m_txs[i] && !tx_ready[i]) begin
          m_txs[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge sys_clk) begin : compare
    bit h;
    int c, r;
    if (check_en) begin
      decode(bus_addr, h, c, r);
      checkOutput("bus_hit", 16'(bus_hit), 16'(h));
      checkOutput("bus_rdata", bus_rdata, model_rdata(bus_addr));
      for (int i = 0; i < NCH; i++) begin
        checkOutput($sformatf("rx_clear[%0d]", i), 16'(rx_clear[i]), 16'(m_rxc[i]));
        checkOutput($sformatf("tx_send[%0d]", i), 16'(tx_send[i]), 16'(m_txs[i]));
        checkOutput($sformatf("tx_data[%0d]", i), 16'(tx_data[8*i +: 8]), 16'(m_txd[i]));
        checkOutput($sformatf("irq_rx[%0d]", i), 16'(irq_rx[i]),
                    16'(m_rie[i] && q_count(i) > 0));
        checkOutput($sformatf("irq_tx[%0d]", i), 16'(irq_tx[i]),
                    16'(m_xie[i] && tx_ready[i] && !m_txs[i]));
      end
    end
  end

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic busRead(input logic [15:0] a, output logic [15:0] d);
    bus_addr   = a;
    bus_rd_stb = 1'b1;
    #1 d = bus_rdata;
    tick();
    bus_rd_stb = 1'b0;
  endtask

  task automatic busWrite(input logic [15:0] a, input logic [15:0] d, input logic b);
    bus_addr   = a;
    bus_wdata  = d;
    bus_byte   = b;
    bus_wr_stb = 1'b1;
    tick();
    bus_wr_stb = 1'b0;
    bus_byte   = 1'b0;
  endtask

  task automatic rxSend(input int ch, input logic [7:0] data);
    int k = 0;
    rx_data[8*ch +: 8] = data;
    rx_data_ready[ch]  = 1'b1;
    do begin
      tick();
      k++;
    end while (!rx_clear[ch] && k < 20);
    checkOutput("rx_accept", 16'(rx_clear[ch]), 16'd1);
    rx_data_ready[ch] = 1'b0;
    tick();
  endtask

  task automatic applyStimulus();
    int op, sel;
    reset      = ($urandom_range(0, 599) == 0);
    bus_rd_stb = 1'b0;
    bus_wr_stb = 1'b0;
    op  = $urandom_range(0, 3);
    sel = $urandom_range(0, 7);
    if (sel < 6)       bus_addr = BASE + 16'($urandom_range(0, NCH * 8 - 1));
    else if (sel == 6) bus_addr = BASE + 16'(NCH * 8) + 16'($urandom_range(0, 7));
    else               bus_addr = 16'($urandom);
    bus_wdata = 16'($urandom);
    bus_byte  = 1'($urandom);
    if (op == 1) bus_rd_stb = 1'b1;
    if (op == 2) bus_wr_stb = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      tx_ready[i] = ($urandom_range(0, 3) != 0);
      if (rx_data_ready[i]) begin
        if (m_rxc[i] && $urandom_range(0, 1) == 1) rx_data_ready[i] = 1'b0;
      end else if (!m_rxc[i] && $urandom_range(0, 2) == 0) begin
        rx_data[8*i +: 8] = 8'($urandom);
        rx_data_ready[i]  = 1'b1;
      end
    end
  endtask

  initial begin : stimulus
    logic [15:0] d;
    reset         = 1'b1;
    bus_addr      = 16'h0000;
    bus_wdata     = 16'h0000;
    bus_rd_stb    = 1'b0;
    bus_wr_stb    = 1'b0;
    bus_byte      = 1'b0;
    rx_data       = '0;
    rx_data_ready = '0;
    tx_ready      = '1;
    tick();
    check_en = 1'b1;
    tick();
    reset = 1'b0;

    busRead(16'o177560, d); checkOutput("rcsr0_reset", d, 16'o000000);
    busRead(16'o177564, d); checkOutput("xcsr0_reset", d, 16'o000200);
    checkOutput("irq_reset", 16'({irq_rx, irq_tx}), 16'd0);
    checkOutput("hs_reset", 16'({rx_clear, tx_send}), 16'd0);

    rxSend(0, 8'h41);
    rxSend(0, 8'h42);
    busRead(16'o177562, d); checkOutput("rbuf_first", d, 16'h0041);
    busRead(16'o177560, d); checkOutput("rcsr_after1", d, 16'o000200);
    busRead(16'o177562, d); checkOutput("rbuf_second", d, 16'h0042);
    busRead(16'o177560, d); checkOutput("rcsr_after2", d, 16'o000000);

    for (int i = 0; i < 16; i++) rxSend(0, 8'h10 + 8'(i));
    rx_data[7:0]     = 8'h20;
    rx_data_ready[0] = 1'b1;
    repeat (3) tick();
    checkOutput("rx17_held", 16'(rx_clear[0]), 16'd0);
    busRead(16'o177562, d); checkOutput("drain_0", d, 16'h0010);
    checkOutput("rx17_accept", 16'(rx_clear[0]), 16'd1);
    rx_data_ready[0] = 1'b0;
    tick();
    for (int i = 1; i <= 16; i++) begin
      busRead(16'o177562, d);
      checkOutput($sformatf("drain_%0d", i), d, (i < 16) ? 16'h0010 + 16'(i) : 16'h0020);
    end
    busRead(16'o177560, d); checkOutput("rcsr_drained", d, 16'o000000);

    busWrite(16'o177560, 16'o000100, 1'b0);
    checkOutput("irq_rx_empty", 16'(irq_rx[0]), 16'd0);
    rxSend(0, 8'h77);
    checkOutput("irq_rx_set", 16'(irq_rx[0]), 16'd1);
    busRead(16'o177562, d); checkOutput("rbuf_irq", d, 16'h0077);
    checkOutput("irq_rx_clr", 16'(irq_rx[0]), 16'd0);
    busWrite(16'o177560, 16'o000000, 1'b0);

    busWrite(16'o177566, 16'h0055, 1'b0);
    checkOutput("tx_send_set", 16'(tx_send[0]), 16'd1);
    busRead(16'o177564, d); checkOutput("xcsr_busy", d, 16'o000000);
    tx_ready[0] = 1'b0;
    tick();
    checkOutput("tx_send_clr", 16'(tx_send[0]), 16'd0);
    busWrite(16'o177566, 16'h00AA, 1'b0);
    checkOutput("tx_drop_send", 16'(tx_send[0]), 16'd0);
    checkOutput("tx_drop_data", 16'(tx_data[7:0]), 16'h0055);
    busRead(16'o177566, d); checkOutput("xbuf_read", d, 16'h0055);
    tx_ready[0] = 1'b1;
    tick();

    busWrite(16'o177566, 16'h005A, 1'b0);
    rxSend(1, 8'h33);
    checkOutput("ch0_no_rx", 16'(rx_clear[0]), 16'd0);
    checkOutput("ch0_tx_hold", 16'(tx_send[0]), 16'd1);
    busRead(16'o177560, d); checkOutput("ch0_rcsr_iso", d, 16'o000000);
    busRead(16'o177570, d); checkOutput("ch1_rcsr", d, 16'o000200);
    busRead(16'o177572, d); checkOutput("ch1_rbuf", d, 16'h0033);
    checkOutput("ch0_txdata", 16'(tx_data[7:0]), 16'h005A);
    checkOutput("ch1_txdata", 16'(tx_data[15:8]), 16'h0000);
    busWrite(16'o177570, 16'o000100, 1'b0);
    busWrite(16'o177571, 16'h0000, 1'b1);
    busRead(16'o177570, d); checkOutput("ch1_odd_byte", d, 16'o000100);
    tx_ready[0] = 1'b0;
    tick();
    tx_ready[0] = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      applyStimulus();
      tick();
    end

    reset         = 1'b1;
    bus_rd_stb    = 1'b0;
    bus_wr_stb    = 1'b0;
    rx_data_ready = '0;
    tick();
    reset = 1'b0;
    checkOutput("final_reset", 16'({irq_rx, irq_tx, rx_clear, tx_send}), 16'd0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
